// File: rtl/fetch_unit_if.sv
// Fetch-stage handshake bundle: instruction-memory request/response channels
// plus the valid/ready instruction hand-off toward the core.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    // Instruction memory request (valid/ready) and response (valid only)
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    // Instruction hand-off toward control unit / register file / immgen
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instruction, pc,
        input  instr_ready
    );

    // Memory / core side
    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instruction, pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and
// holds the fetched instruction until the core retires it.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    fetch_unit_if.master      bus,
    input  logic              pc_write,
    input  logic              pc_sel,
    input  logic [XLEN-1:0]   branch_target,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              retire;

    assign retire = instr_valid_q && bus.instr_ready;

    // Next-state and next-output computation for the fetch FSM
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        req_valid_d   = req_valid_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        misalign_d    = 1'b0;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                state_d     = REQ;
                req_valid_d = 1'b1;
            end
            REQ: begin
                // Address is pc_q, which cannot change here, so it is stable while stalled
                if (req_valid_q && bus.imem_req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d       = HOLD;
                    instr_d       = bus.imem_rsp_data;
                    instr_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (retire) begin
                    state_d       = REQ;
                    req_valid_d   = 1'b1;
                    instr_valid_d = 1'b0;
                    cnt_d         = cnt_q + CNT_W'(1);
                    // pc_write=0 leaves pc alone so the same address is refetched
                    if (pc_write) begin
                        if (pc_sel) begin
                            pc_d       = {branch_target[XLEN-1:2], 2'b00};
                            misalign_d = (branch_target[1:0] != 2'b00);
                        end else begin
                            pc_d = pc_q + XLEN'(4);
                        end
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // Register FSM state and all outputs; reset discards any transaction in flight
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            // NOTE: every flop, including the instruction register, has an explicit reset value.
            state_q       <= IDLE;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP;
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instruction    = instr_q;
    assign bus.pc             = pc_q;
    assign misalign_err       = misalign_q;
    assign retire_cnt         = cnt_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the processor core's decode/execute path. It owns the program counter and issues word reads to instruction memory over a valid/ready request channel plus a valid-only response channel. It holds each fetched instruction on a valid/ready output toward the control unit, register file and immediate generator. The PC advances only when the control unit retires the instruction, to PC+4 or to a branch/jump target.

Parameters:
XLEN, 32, width of PC and addresses
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock, rising-edge
arst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  fetch address (= pc)
imem_rsp_valid  input  1  response data valid (single-cycle pulse)
imem_rsp_data  input  32  fetched instruction word
instr_valid  output  1  instruction available to core
instr_ready  input  1  core consumes instruction
instruction  output  32  held instruction word
pc  output  XLEN  address of held/pending instruction
pc_write  input  1  from control unit: update PC on retire
pc_sel  input  1  0: PC+4, 1: branch_target
branch_target  input  XLEN  next PC when pc_sel=1
misalign_err  output  1  one-cycle pulse: target bits[1:0] nonzero
retire_cnt  output  CNT_W  count of retired instructions

Behaviour:
- Reset (async assert, sync-released by the flop update): state=IDLE, pc=RESET_PC, instruction=32'h0000_0013 (NOP), imem_req_valid=0, instr_valid=0, misalign_err=0, retire_cnt=0. A reset mid-transaction discards any outstanding request or response. A response arriving after reset is ignored.
- All outputs are registered. imem_addr is wired to pc.
- FSM states:
  - IDLE -> REQ unconditionally, on the first edge after reset release.
  - REQ: imem_req_valid=1. On imem_req_valid & imem_req_ready -> WAIT, and imem_req_valid drops on the next cycle. imem_addr must stay stable while valid is high and ready is low.
  - WAIT: on imem_rsp_valid, capture imem_rsp_data into instruction, set instr_valid=1 -> HOLD. Minimum latency from request accept to instr_valid is 1 cycle after the response pulse.
  - HOLD: instruction and pc are held stable while instr_valid=1 and instr_ready=0. On instr_valid & instr_ready (retire):
    - instr_valid is cleared.
    - retire_cnt increments, wrapping modulo 2^CNT_W.
    - If pc_write=1: pc <= pc_sel ? {branch_target[XLEN-1:2],2'b00} : pc+4, with PC+4 wrapping modulo 2^XLEN.
    - If pc_write=0: pc is unchanged, so the same address is refetched (replay).
    - The state then goes to REQ.
- misalign_err pulses for 1 cycle on retire when pc_write=1, pc_sel=1 and branch_target[1:0]!=0. The target is still taken with its low bits forced to 0.
- imem_rsp_valid outside WAIT is ignored. imem_req_ready outside REQ is ignored.
- pc_write, pc_sel and branch_target are sampled only on the retire edge.
- At most one outstanding request; no prefetch.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT with same-cycle response, HOLD with instr_ready=1).

Test Plan:
- Reset release, imem_req_ready=1, response 1 cycle later with data 32'h00500093, instr_ready=1, pc_write=1, pc_sel=0 -> first imem_addr=0x0, instruction=0x00500093, next imem_addr=0x4, retire_cnt=1.
- Hold imem_req_ready=0 for 5 cycles in REQ -> imem_req_valid stays 1 and imem_addr=0x0 stays stable; request accepted only on the ready cycle.
- instr_ready=0 for 4 cycles in HOLD -> instr_valid, instruction and pc stable; no new request issued; retire_cnt unchanged.
- Retire with pc_write=1, pc_sel=1, branch_target=0x0000_0102 -> pc=0x0000_0100, misalign_err pulses once; with target 0x40, pc=0x40 and no pulse.
- Retire with pc_write=0 at pc=0x8 -> refetch at 0x8, retire_cnt increments. Also pc=0xFFFF_FFFC with pc_sel=0 -> pc wraps to 0x0.
- Assert arst_n=0 while in WAIT, then deliver imem_rsp_valid during reset and after release -> outputs at reset values, pc=RESET_PC, stale response not captured, new fetch from RESET_PC.
